// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master's state enumeration.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_BURST = 3'd2,
    ST_LAST  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;
endpackage

// File: rtl/ahb_master_if.sv
// Command/response side plus AHB-Lite bus of the master; master = DUT view, slave = environment view.
interface ahb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_burst;
  logic [31:0] cmd_addr;
  logic [31:0] wdata;
  logic        wdata_ack;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        done;
  logic        err;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_burst, cmd_addr, wdata, hready, hresp, hrdata,
    output cmd_ready, wdata_ack, rsp_valid, rsp_rdata, done, err,
           haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_burst, cmd_addr, wdata, hready, hresp, hrdata,
    input  cmd_ready, wdata_ack, rsp_valid, rsp_rdata, done, err,
           haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata
  );
endinterface

// File: rtl/ahb_master.sv
// AHB-Lite master: one SINGLE/INCR4 word command at a time, address of beat n+1 overlaps data of beat n.
// Bus outputs registered and frozen while hready=0; done pulses the cycle after the last data phase.
module ahb_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic         hclk,
  input  logic         hresetn,
  ahb_master_if.master bus
);

  state_t     state, state_nxt;
  logic [1:0] beat_cnt;
  logic       accept, addr_acc, final_beat, in_data, data_ok, data_err;

  assign bus.hsize     = HSIZE_WORD;
  assign bus.hmastlock = 1'b0;
  assign bus.hprot     = HPROT_VAL;

  assign accept     = bus.cmd_valid & bus.cmd_ready & (state == ST_IDLE);
  assign in_data    = (state == ST_BURST) | (state == ST_LAST);
  assign data_ok    = in_data & bus.hready & ~bus.hresp;
  assign data_err   = in_data & ~bus.hready & bus.hresp;
  assign addr_acc   = bus.hready & ((state == ST_ADDR) | ((state == ST_BURST) & ~bus.hresp));
  assign final_beat = (state == ST_ADDR) ? (bus.hburst == HBURST_SINGLE) : (beat_cnt == 2'd3);
  // Write data is sampled on the edge that accepts its address phase, so the ack covers that cycle.
  assign bus.wdata_ack = addr_acc & bus.hwrite;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ADDR;
      ST_ADDR:  if (addr_acc) state_nxt = final_beat ? ST_LAST : ST_BURST;
      ST_BURST: begin
        if (data_err)                    state_nxt = ST_ERR;
        else if (addr_acc && final_beat) state_nxt = ST_LAST;
      end
      ST_LAST: begin
        if (data_err)     state_nxt = ST_ERR;
        else if (data_ok) state_nxt = ST_IDLE;
      end
      ST_ERR:   if (bus.hready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      bus.haddr     <= 32'h0;
      bus.htrans    <= HTRANS_IDLE;
      bus.hwrite    <= 1'b0;
      bus.hburst    <= HBURST_SINGLE;
      bus.hwdata    <= 32'h0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      beat_cnt      <= 2'd0;
    end else begin
      bus.cmd_ready <= (state_nxt == ST_IDLE);
      bus.rsp_valid <= data_ok & ~bus.hwrite;
      bus.done      <= ((state == ST_LAST) & data_ok) | ((state == ST_ERR) & bus.hready);
      bus.err       <= (state == ST_ERR) & bus.hready;
      if (data_ok && !bus.hwrite) bus.rsp_rdata <= bus.hrdata;

      if (accept) begin
        bus.haddr  <= bus.cmd_addr;
        bus.hwrite <= bus.cmd_write;
        bus.hburst <= bus.cmd_burst ? HBURST_INCR4 : HBURST_SINGLE;
        bus.htrans <= HTRANS_NONSEQ;
        beat_cnt   <= 2'd0;
      end else if (addr_acc) begin
        beat_cnt <= beat_cnt + 2'd1;
        if (bus.hwrite) bus.hwdata <= bus.wdata;
        if (final_beat) begin
          bus.htrans <= HTRANS_IDLE;
        end else begin
          bus.htrans <= HTRANS_SEQ;
          bus.haddr  <= bus.haddr + 32'd4;
        end
      end else if (data_err || state_nxt == ST_IDLE) begin
        // An ERROR cancels the pending beat, so the bus goes idle before the second response cycle.
        bus.htrans <= HTRANS_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Directed + randomized bench for ahb_master with a behavioural AHB slave and a command-level reference model.
module tb_ahb_master;
  import ahb_pkg::*;

  logic hclk, hresetn;
  ahb_master_if bus();

  ahb_master #(.HPROT_VAL(4'b0011)) dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // slave / monitor state
  logic [31:0] smem[logic [31:0]];
  logic [31:0] mmem[logic [31:0]];
  logic [31:0] wq[4];
  int          widx, cfg_wait, cfg_err_beat, beat_no, dp_wait, err_stage;
  logic        dp_active, dp_write, dp_err;
  logic [31:0] dp_addr;
  logic        nx_ready, nx_resp;
  logic [31:0] nx_rdata;
  logic        p_valid, p_hready, p_hresp;
  logic [31:0] p_addr, p_wdata;
  logic [1:0]  p_trans;
  int          done_cnt, err_cnt, ack_cnt, addr_cyc, done_cyc;
  logic [31:0] obs_addr[$];
  logic [1:0]  obs_trans[$];
  logic [2:0]  obs_burst[$];
  logic        obs_write[$];
  logic [31:0] obs_rd[$];
  logic [31:0] obs_wr[$];

  // stimulus / model scratch
  logic        r_wr, r_bu;
  logic [31:0] r_addr, ea;
  int          r_eb, nb, nacc, ncomp, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: random/fixed wait states, two-cycle ERROR on a chosen beat.
  initial begin
    forever begin
      @(negedge hclk);
      cyc++;
      if (!hresetn) begin
        dp_active = 1'b0; err_stage = 0; p_valid = 1'b0;
        nx_ready = 1'b1; nx_resp = 1'b0; nx_rdata = 32'h0;
      end else begin
        if (p_valid && !p_hready && !p_hresp) begin
          chk("stall_haddr", bus.haddr, p_addr);
          chk("stall_htrans", bus.htrans, p_trans);
          chk("stall_hwdata", bus.hwdata, p_wdata);
        end
        if (p_valid && !p_hready && p_hresp) chk("err_htrans_idle", bus.htrans, HTRANS_IDLE);
        if (bus.wdata_ack) begin ack_cnt++; widx++; end
        if (bus.rsp_valid) obs_rd.push_back(bus.rsp_rdata);
        if (bus.done) begin
          done_cnt++; done_cyc = cyc;
          if (bus.err) err_cnt++;
        end else if (bus.err) chk("err_without_done", bus.err, 1'b0);
        if (dp_active && bus.hready) begin
          if (!bus.hresp && dp_write) begin
            smem[dp_addr] = bus.hwdata;
            obs_wr.push_back(bus.hwdata);
          end
          dp_active = 1'b0; err_stage = 0;
        end
        if (bus.hready && bus.htrans[1]) begin
          obs_addr.push_back(bus.haddr); obs_trans.push_back(bus.htrans);
          obs_burst.push_back(bus.hburst); obs_write.push_back(bus.hwrite);
          if (bus.htrans == HTRANS_NONSEQ) begin beat_no = 0; addr_cyc = cyc; end
          beat_no++;
          dp_active = 1'b1; dp_addr = bus.haddr; dp_write = bus.hwrite;
          dp_err  = (beat_no == cfg_err_beat);
          dp_wait = (cfg_wait < 0) ? int'($urandom_range(0, 2)) : cfg_wait;
        end
        p_valid = 1'b1; p_addr = bus.haddr; p_trans = bus.htrans; p_wdata = bus.hwdata;
        p_hready = bus.hready; p_hresp = bus.hresp;
        nx_ready = 1'b1; nx_resp = 1'b0; nx_rdata = $urandom;
        if (dp_active) begin
          if (dp_err) begin
            nx_resp = 1'b1; nx_ready = (err_stage != 0); err_stage = 1;
          end else if (dp_wait > 0) begin
            nx_ready = 1'b0; dp_wait--;
          end else if (!dp_write) begin
            nx_rdata = smem.exists(dp_addr) ? smem[dp_addr] : dp_addr >> 2;
          end
        end
      end
      @(posedge hclk);
      #1;
      bus.hready = nx_ready; bus.hresp = nx_resp; bus.hrdata = nx_rdata;
      bus.wdata = (widx < 4) ? wq[widx] : $urandom;
    end
  end

  // Issue one command, wait for done, then compare against the command-level model.
  task automatic run_cmd(input logic wr, input logic bu, input logic [31:0] a, input int eb, input int wmode);
    obs_addr.delete(); obs_trans.delete(); obs_burst.delete(); obs_write.delete();
    obs_rd.delete(); obs_wr.delete();
    done_cnt = 0; err_cnt = 0; ack_cnt = 0; widx = 0;
    cfg_err_beat = eb; cfg_wait = wmode;
    @(posedge hclk); #1;
    bus.wdata = wq[0];
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_burst = bu; bus.cmd_addr = a;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin @(posedge hclk); #1; n++; end
    chk("cmd_accept_timeout", n, n < 50 ? n : 50 - 1);
    @(posedge hclk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 200) begin @(posedge hclk); #1; n++; end
    chk("done_timeout", done_cnt > 0, 1'b1);
    repeat (2) @(posedge hclk);
    #1;
    nb    = bu ? 4 : 1;
    nacc  = (eb != 0) ? eb : nb;
    ncomp = (eb != 0) ? eb - 1 : nb;
    chk("n_addr_phases", obs_addr.size(), nacc);
    for (int i = 0; i < nacc && i < obs_addr.size(); i++) begin
      chk("haddr", obs_addr[i], a + 32'(4 * i));
      chk("htrans", obs_trans[i], (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
      chk("hburst", obs_burst[i], bu ? HBURST_INCR4 : HBURST_SINGLE);
      chk("hwrite", obs_write[i], wr);
    end
    chk("n_rsp", obs_rd.size(), wr ? 0 : ncomp);
    chk("n_wr", obs_wr.size(), wr ? ncomp : 0);
    chk("wdata_ack_cnt", ack_cnt, wr ? nacc : 0);
    for (int i = 0; i < ncomp; i++) begin
      ea = a + 32'(4 * i);
      if (wr) begin
        if (i < obs_wr.size()) chk("hwdata", obs_wr[i], wq[i]);
        mmem[ea] = wq[i];
      end else if (i < obs_rd.size()) begin
        chk("rsp_rdata", obs_rd[i], mmem.exists(ea) ? mmem[ea] : ea >> 2);
      end
    end
    chk("done_cnt", done_cnt, 1);
    chk("err_cnt", err_cnt, (eb != 0) ? 1 : 0);
    chk("hsize", bus.hsize, 3'b010);
    chk("hmastlock", bus.hmastlock, 1'b0);
    chk("hprot", bus.hprot, 4'b0011);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_htrans"}, bus.htrans, 2'b00);
    chk({tag, "_haddr"}, bus.haddr, 32'h0);
    chk({tag, "_hwrite"}, bus.hwrite, 1'b0);
    chk({tag, "_hburst"}, bus.hburst, 3'b000);
    chk({tag, "_hwdata"}, bus.hwdata, 32'h0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
    chk({tag, "_wdata_ack"}, bus.wdata_ack, 1'b0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_err"}, bus.err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t reached, required completion before it", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    hresetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_burst = 1'b0; bus.cmd_addr = 32'h0;
    bus.wdata = 32'h0; bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'h0;
    for (int i = 0; i < 4; i++) wq[i] = 32'h0;
    widx = 0; cfg_wait = 0; cfg_err_beat = 0;
    #3;
    chk_reset_outputs("por");
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(posedge hclk); #1;
    chk("cmd_ready_after_reset", bus.cmd_ready, 1'b1);

    // SINGLE write, zero wait: done two cycles after the address phase
    wq[0] = 32'hDEADBEEF;
    run_cmd(1'b1, 1'b0, 32'h0000_0010, 0, 0);
    chk("single_wr_done_latency", done_cyc - addr_cyc, 2);
    if (obs_wr.size() > 0) chk("single_wr_hwdata", obs_wr[0], 32'hDEADBEEF);

    // SINGLE read with two wait states
    run_cmd(1'b0, 1'b0, 32'h0000_000C, 0, 2);
    chk("single_rd_done_latency", done_cyc - addr_cyc, 4);
    if (obs_rd.size() > 0) chk("single_rd_data", obs_rd[0], 32'h0000_0003);

    // INCR4 read, zero wait
    run_cmd(1'b0, 1'b1, 32'h0000_0020, 0, 0);
    chk("incr4_rd_done_latency", done_cyc - addr_cyc, 5);
    if (obs_rd.size() == 4) chk("incr4_rd_last", obs_rd[3], 32'h0000_000B);

    // INCR4 write aborted by ERROR on beat 2
    for (int i = 0; i < 4; i++) wq[i] = $urandom;
    run_cmd(1'b1, 1'b1, 32'h0000_0000, 2, 0);

    // Address wrap across 2^32, write then read back
    for (int i = 0; i < 4; i++) wq[i] = $urandom;
    run_cmd(1'b1, 1'b1, 32'hFFFF_FFF8, 0, -1);
    run_cmd(1'b0, 1'b1, 32'hFFFF_FFF8, 0, -1);

    // Reset during beat 3 of an INCR4 read
    cfg_wait = 0; cfg_err_beat = 0;
    @(posedge hclk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_burst = 1'b1; bus.cmd_addr = 32'h0000_0040;
    n = 0;
    while (!(bus.htrans == HTRANS_SEQ && bus.haddr == 32'h0000_0048) && n < 30) begin
      @(posedge hclk); #1;
      if (bus.htrans != HTRANS_IDLE) bus.cmd_valid = 1'b0;
      n++;
    end
    chk("beat3_reached", bus.haddr, 32'h0000_0048);
    bus.cmd_valid = 1'b0;
    #2 hresetn = 1'b0;
    done_cnt = 0;
    #1;
    chk_reset_outputs("midburst");
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    repeat (5) @(posedge hclk);
    #1;
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_after_reset", bus.htrans, HTRANS_IDLE);
    run_cmd(1'b0, 1'b1, 32'h0000_0040, 0, 0);

    // Randomized commands
    for (int k = 0; k < 16; k++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_bu   = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 31)) << 2);
      r_eb   = ($urandom_range(0, 3) == 0) ? (r_bu ? int'($urandom_range(1, 4)) : 1) : 0;
      for (int i = 0; i < 4; i++) wq[i] = $urandom;
      run_cmd(r_wr, r_bu, r_addr, r_eb, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, driven constant on hprot (non-cacheable privileged data).
REQ-002 SHALL have ports:
- hclk  in  1  clock; all logic on rising edge
- hresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_burst  in  1  0=SINGLE, 1=INCR4
- cmd_addr  in  32  start byte address, word aligned
- wdata  in  32  write data for current data-phase beat
- wdata_ack  out  1  one-cycle pulse when wdata consumed
- rsp_valid  out  1  one-cycle pulse per completed read beat
- rsp_rdata  out  32  read data, valid with rsp_valid
- done  out  1  one-cycle pulse at command end
- err  out  1  with done: command aborted by ERROR response
- haddr  out  32; hwrite  out  1; hsize  out  3; hburst  out  3; hprot  out  4; htrans  out  2; hmastlock  out  1; hwdata  out  32
- hready  in  1; hresp  in  1; hrdata  in  32

Function
REQ-003 SHALL drive hsize=3'b010 (word), hmastlock=0 at all times.
REQ-004 SHALL assert cmd_ready only in IDLE; acceptance moves IDLE->ADDR next cycle.
REQ-005 ADDR SHALL drive htrans=NONSEQ, haddr=cmd_addr, hwrite=cmd_write, hburst=SINGLE(000) or INCR4(011); held until hready=1.
REQ-006 INCR4 SHALL issue beats 2-4 as SEQ at haddr+4 each, address of beat n+1 overlapping data phase of beat n (state BURST); address wraps modulo 2^32.
REQ-007 On the address phase of the final beat accepted, SHALL go to LAST, drive htrans=IDLE and await final data phase.
REQ-008 All address/control outputs and hwdata SHALL hold stable while hready=0.
REQ-009 Write: hwdata SHALL equal wdata registered at start of each data phase; wdata_ack pulses that cycle.
REQ-010 Read: on hready=1 & hresp=0 in a read data phase, rsp_valid=1 and rsp_rdata=hrdata the next cycle.
REQ-011 done SHALL pulse one cycle after the final data phase completes; state returns to IDLE same cycle; new command acceptable next cycle (no back-to-back overlap).
REQ-012 On hresp=1 & hready=0 (first ERROR cycle), SHALL drive htrans=IDLE next cycle, cancel remaining beats, enter ERR; on second cycle (hresp=1 & hready=1) pulse done&err, no rsp_valid, return IDLE.
REQ-013 States: IDLE, ADDR, BURST, LAST, ERR; illegal encodings SHALL return to IDLE.
REQ-014 A 2-bit beat counter SHALL track issued beats; SINGLE treated as 1 beat.

Reset
REQ-015 hresetn low SHALL asynchronously force: state IDLE, htrans=IDLE(00), haddr=0, hwrite=0, hburst=0, hwdata=0, cmd_ready=0 until release, wdata_ack=rsp_valid=done=err=0, rsp_rdata=0, beat counter=0.
REQ-016 Reset mid-burst SHALL abandon the transfer; no done pulse after release.

Structure
REQ-017 Package ahb_pkg SHALL hold HTRANS codes (IDLE, BUSY, NONSEQ, SEQ), HBURST codes (SINGLE, INCR4), HSIZE_WORD, state enumeration.
REQ-018 Single module, no sub-module; mated to the existing ahb_slave in benches.

Verification
REQ-019 SINGLE write 0x0000_0010, wdata 0xDEADBEEF, hready=1 -> htrans NONSEQ one cycle, hwdata 0xDEADBEEF next, done 2 cycles after address phase.
REQ-020 SINGLE read 0x0000_000C, slave inserts 2 wait states, hrdata 0x0000_0003 -> outputs stable during waits, rsp_rdata 0x0000_0003, done.
REQ-021 INCR4 read 0x0000_0020 -> haddr 0x20/0x24/0x28/0x2C, htrans NONSEQ,SEQ,SEQ,SEQ, hburst 011, four rsp_valid with 0x08..0x0B.
REQ-022 INCR4 write 0x0000_0000, ERROR on beat 2 -> htrans IDLE after first error cycle, no beat 3/4, done&err pulse.
REQ-023 hresetn low during beat 3 of INCR4 -> all outputs at reset values immediately; next command completes normally.
